pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the generic successor of the fixed per-stage latches between EX, MEM and WB. It carries an arbitrary-width payload plus a control field under a valid/ready handshake, supports stall and flush, and can optionally include a one-entry skid buffer so `in_ready` is driven from a flop. It also keeps saturating stall and bubble counters for pipeline performance debug. One instance sits at each stage boundary of the pipelined CPU.

## Interface
Parameters:
- `DATA_W`, 96: payload width (PC, inst, ALU result, rs2 data, register indices, …).
- `CTRL_W`, 8: control-field width (MemRead/MemWrite/RegWrite/MemtoReg, …). Forced to zero on every bubble.
- `SKID`, 1: 1 adds a skid entry and makes `in_ready` registered; 0 gives a single register with combinational `in_ready`.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: upstream beat valid.
- `in_ready`, out, 1: stage accepts a beat this cycle.
- `in_data`, in, DATA_W: upstream payload.
- `in_ctrl`, in, CTRL_W: upstream control.
- `out_valid`, out, 1: downstream beat valid.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, DATA_W: registered payload.
- `out_ctrl`, out, CTRL_W: registered control; 0 whenever `out_valid`=0.
- `stall`, in, 1: hazard-unit freeze; when high, no beat leaves, regardless of `out_ready`.
- `flush`, in, 1: discard all held beats and the beat offered this cycle.
- `cnt_clr`, in, 1: synchronous clear of both counters.
- `stall_cnt`, out, CNT_W: cycles in which a valid beat was held.
- `bubble_cnt`, out, CNT_W: cycles with `out_valid`=0.

## Operation
- `acc_out` = `out_valid` & `out_ready` & ~`stall`.
- `acc_in` = `in_valid` & `in_ready`.
- `in_ready` is 0 whenever `flush`=1.
- SKID=0:
  - `in_ready` = ~`flush` & (~`out_valid` | (`out_ready` & ~`stall`)).
  - On `acc_in`, load the main register with data and ctrl, and set `out_valid`.
  - If `acc_out` and not `acc_in`, clear `out_valid`.
- SKID=1: main register (drives outputs) plus a skid register. `in_ready` = ~`skid_valid` & ~`flush`.
- SKID=1 state machine over (main_valid, skid_valid):
  - EMPTY(0,0):
    - `acc_in` → ONE.
  - ONE(1,0):
    - `acc_in` & `acc_out` → ONE, with new data in main.
    - `acc_in` & ~`acc_out` → TWO, with the beat captured into skid.
    - ~`acc_in` & `acc_out` → EMPTY.
    - Otherwise hold.
  - TWO(1,1):
    - `acc_out` → ONE, with skid moved into main.
    - Otherwise hold.
    - `acc_in` is impossible here because `in_ready`=0.
- Beat order is strictly preserved. No beat is duplicated or dropped except on flush.
- Flush or rst, with priority over everything:
  - Next cycle all valids are 0, `out_ctrl`=0 and `out_data`=0.
  - The FSM returns to EMPTY.
  - The offered input beat is discarded.
- Bubble rule: any cycle with `out_valid`=0 presents `out_ctrl`=0. `out_data` holds its last value, or 0 after rst/flush.
- `stall_cnt` increments when `out_valid` & ~(`out_ready` & ~`stall`).
- `bubble_cnt` increments when ~`out_valid`.
- Both counters saturate at 2^CNT_W−1.
- Counter priority, highest first: rst, then `cnt_clr`, then increment. `flush` does not clear the counters.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N (one cycle), for either SKID setting.
- Throughput: 1 beat per cycle when downstream is ready and `stall`=0.
- SKID=1: `in_ready` depends only on flops and `flush`; there is no path from `out_ready` or `stall`. Holding throughput requires 2 entries, because the skid absorbs the beat in flight when downstream stops.
- SKID=0: there is a combinational path from `out_ready`/`stall` to `in_ready`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ctrl`=0.
  - `stall_cnt`=0, `bubble_cnt`=0.
  - `in_ready`=1 in the first cycle after rst drops.
- Simultaneous events:
  - `flush` with `acc_out` in the same cycle: the downstream transfer still counts for that cycle; the state is empty afterwards.
  - `rst` mid-stream: all held beats are lost and no partial state survives.

## Test plan
- Streaming: SKID=1, `out_ready`=1, beats 0x1..0x8 on consecutive cycles → outputs 0x1..0x8 on consecutive cycles, one cycle late; `stall_cnt`=0.
- Backpressure: `out_ready`=0 while 3 beats are offered → two are accepted (main, skid) and `in_ready`=0 on the 3rd; after release, the output order is A, B, then C. `stall_cnt` counts the held cycles exactly.
- Stall versus ready: `out_ready`=1, `stall`=1 for 4 cycles with a valid beat held → the beat is unchanged, `stall_cnt` +4, and the beat is delivered on the first cycle after `stall` drops.
- Flush: with the stage in TWO, assert `flush` while `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `out_data`=0. None of the three beats ever appears, and `bubble_cnt` starts incrementing.
- Counter edges: CNT_W=4, idle for 20 cycles → `bubble_cnt`=15 (saturated). Assert `cnt_clr` together with an increment condition → `bubble_cnt`=0.
- SKID=0 regression: repeat the streaming and backpressure cases → identical output order, and `in_ready` tracks `out_ready` in the same cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall/flush and an optional
// skid entry so in_ready can come straight from a flop; keeps stall/bubble counters.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              main_valid, skid_valid;
  logic              acc_in, acc_out;
  logic              load_main, load_skid, skid_to_main;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);
  assign acc_out    = main_valid & out_ready & ~stall;
  assign acc_in     = in_valid & in_ready;

  // Without a skid the stage is only ready when the held beat leaves this cycle,
  // so acc_in in ONE always coincides with acc_out and TWO is never entered.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~skid_valid & ~flush;
    end else begin : g_noskid
      assign in_ready = ~flush & (~main_valid | (out_ready & ~stall));
    end
  endgenerate

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: if (acc_in) begin
        state_nxt = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (acc_in && acc_out) begin
          load_main = 1'b1;
        end else if (acc_in) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (acc_out) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (acc_out) begin
        state_nxt    = ONE;
        skid_to_main = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (skid_to_main) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;

  // Flush deliberately leaves the counters alone; only rst and cnt_clr zero them.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !(out_ready && !stall) && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (!main_valid && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid and no-skid instances share stimulus,
// a 4-bit-counter instance covers saturation.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, stall, flush, cnt_clr;
  logic [15:0] in_data;
  logic [3:0]  in_ctrl;

  logic        ir1, ov1, ir0, ov0, ir4, ov4;
  logic [15:0] od1, od0, od4;
  logic [3:0]  oc1, oc0, oc4;
  logic [15:0] sc1, bc1, sc0, bc0;
  logic [3:0]  sc4, bc4;

  int n_chk = 0;
  int n_fail = 0;
  bit sel = 1'b1;
  logic [31:0] v_ir, v_ov, v_od, v_oc, v_sc, v_bc;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_ctrl(oc1), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc1), .bubble_cnt(bc1));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_ctrl(oc0), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc0), .bubble_cnt(bc0));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(1), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .out_ctrl(oc4), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc4), .bubble_cnt(bc4));

  // View of whichever of u1/u0 the current phase targets
  always_comb begin
    v_ir = sel ? 32'(ir1) : 32'(ir0);
    v_ov = sel ? 32'(ov1) : 32'(ov0);
    v_od = sel ? 32'(od1) : 32'(od0);
    v_oc = sel ? 32'(oc1) : 32'(oc0);
    v_sc = sel ? 32'(sc1) : 32'(sc0);
    v_bc = sel ? 32'(bc1) : 32'(bc0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (sel=%0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    #1;
    chk("clr_stall", v_sc, 0);
    chk("clr_bubble", v_bc, 0);
  endtask

  task automatic stream();
    clr_cnt();
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_data  = 16'(k + 1);
      in_ctrl  = 4'(k + 1);
      #1;
      chk("str_ready", v_ir, 1);
      chk("str_valid", v_ov, (k > 0) ? 1 : 0);
      if (k > 0) begin
        chk("str_data", v_od, k);
        chk("str_ctrl", v_oc, k);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("str_end_valid", v_ov, 0);
    chk("str_end_ctrl", v_oc, 0);
    chk("str_end_data_hold", v_od, 8);
    chk("str_stall_cnt", v_sc, 0);
    chk("str_bubble_cnt", v_bc, 1);
  endtask

  task automatic bp();
    logic [15:0] bd [3];
    logic [3:0]  bcx [3];
    int i, o;
    logic rdy;
    bd[0] = 16'h0A0A; bd[1] = 16'h0B0B; bd[2] = 16'h0C0C;
    bcx[0] = 4'hA;    bcx[1] = 4'hB;    bcx[2] = 4'hC;
    i = 0;
    o = 0;
    clr_cnt();
    for (int c = 1; c <= 7; c++) begin
      out_ready = (c >= 4);
      in_valid  = (i < 3);
      in_data   = (i < 3) ? bd[i] : 16'h0;
      in_ctrl   = (i < 3) ? bcx[i] : 4'h0;
      #1;
      rdy = v_ir[0];
      if (c == 2) chk("bp_ready_c2", v_ir, sel ? 1 : 0);
      if (c == 3) chk("bp_ready_c3", v_ir, 0);
      if (c == 4) chk("bp_ready_c4", v_ir, sel ? 0 : 1);
      if (c == 2 || c == 3) chk("bp_hold_A", v_od, 32'h0A0A);
      if (c == 7) begin
        chk("bp_stall_cnt", v_sc, 2);
        chk("bp_bubble_cnt", v_bc, 1);
        chk("bp_empty", v_ov, 0);
      end
      if (v_ov[0] && out_ready) begin
        if (o < 3) begin
          chk("bp_order_data", v_od, 32'(bd[o]));
          chk("bp_order_ctrl", v_oc, 32'(bcx[o]));
        end
        o++;
      end
      tick();
      if (in_valid && rdy) i++;
    end
    chk("bp_beats_out", o, 3);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0; in_data = '0; in_ctrl = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int s = 1; s >= 0; s--) begin
      sel = s[0];
      #1;
      chk("rst_valid", v_ov, 0);
      chk("rst_data", v_od, 0);
      chk("rst_ctrl", v_oc, 0);
      chk("rst_stall_cnt", v_sc, 0);
      chk("rst_bubble_cnt", v_bc, 0);
      chk("rst_ready", v_ir, 1);
    end
    sel = 1'b1;

    // idle: 4-bit bubble counter saturates, 16-bit one keeps counting
    repeat (20) tick();
    chk("sat_bubble4", 32'(bc4), 15);
    chk("sat_stall4", 32'(sc4), 0);
    chk("idle_bubble16", v_bc, 20);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    chk("clr_beats_inc_bubble4", 32'(bc4), 0);
    tick();
    chk("after_clr_bubble4", 32'(bc4), 1);

    sel = 1'b1;
    stream();
    bp();

    // stall with out_ready=1 holds the beat
    clr_cnt();
    out_ready = 1'b1; stall = 1'b0;
    in_valid = 1'b1; in_data = 16'h0D0D; in_ctrl = 4'hD;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("stall_valid", v_ov, 1);
      chk("stall_data", v_od, 32'h0D0D);
      chk("stall_ctrl", v_oc, 32'hD);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("stall_release_valid", v_ov, 1);
    chk("stall_release_data", v_od, 32'h0D0D);
    chk("stall_cnt4", v_sc, 4);
    tick();
    chk("stall_delivered", v_ov, 0);
    chk("stall_bubble", v_bc, 1);

    // flush while in TWO with a beat offered
    clr_cnt();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00F1; in_ctrl = 4'h1;
    tick();
    in_data = 16'h00F2; in_ctrl = 4'h2;
    tick();
    in_data = 16'h00F3; in_ctrl = 4'h3; flush = 1'b1;
    #1;
    chk("flush_ready", v_ir, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_valid", v_ov, 0);
    chk("flush_ctrl", v_oc, 0);
    chk("flush_data", v_od, 0);
    chk("flush_bubble0", v_bc, 1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("flush_no_beat", v_ov, 0);
      chk("flush_bubble_inc", v_bc, 2 + j);
    end

    // reset mid-stream from TWO
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0E01; in_ctrl = 4'h5;
    tick();
    in_data = 16'h0E02;
    tick();
    rst = 1'b1; in_data = 16'h0E03;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", v_ov, 0);
    chk("mid_rst_data", v_od, 0);
    chk("mid_rst_ctrl", v_oc, 0);
    chk("mid_rst_stall_cnt", v_sc, 0);
    chk("mid_rst_ready", v_ir, 1);

    sel = 1'b0;
    stream();
    bp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
